mem_write_scoreboard: RTL and testbench
=======================================

// Module: mem_write_scoreboard
// PURPOSE
//  Synthesizable self-checking scoreboard for the data-memory write port of the MIPS cores.
//  Holds a queue of expected (address, data) store pairs and compares every observed store against its head.
//  Stores to one programmable "scratch" address are ignored.
//  Reports pass, fail cause and the first offending store, so benches and FPGA builds share one checker.
//  Sits beside top, tapping data_addr/write_data/mem_write.
// PARAMETERS
//  ADDR_W      32    width of data_addr / expected address
//  DATA_W      32    width of write_data / expected data
//  DEPTH       8     expected-queue entries (power of two, >=2)
//  TIMEOUT     1000  cycles allowed in RUN before fail; 0 disables timeout
//  IGNORE_EN   1     1: stores to IGNORE_ADDR are skipped, never compared
//  IGNORE_ADDR 80    scratch address skipped when IGNORE_EN=1
//  STRICT      0     1: non-ignored store seen in PASS moves to FAIL (cause EXTRA)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  reset       in   1       synchronous, active-high; clears everything
//  exp_wr      in   1       push (exp_addr, exp_data) into queue; honoured in IDLE only
//  exp_addr    in   ADDR_W  expected store address
//  exp_data    in   DATA_W  expected store data
//  start       in   1       IDLE->RUN; ignored in other states
//  mem_write   in   1       store strobe from core, sampled each rising edge
//  data_addr   in   ADDR_W  store address
//  write_data  in   DATA_W  store data
//  busy        out  1       1 in RUN
//  done        out  1       1 in PASS or FAIL (sticky until reset)
//  pass        out  1       1 in PASS only
//  fail_cause  out  2       0 NONE, 1 MISMATCH, 2 TIMEOUT, 3 EXTRA
//  err_addr    out  ADDR_W  data_addr of offending store (0 for TIMEOUT)
//  err_data    out  DATA_W  write_data of offending store (0 for TIMEOUT)
//  match_cnt   out  $clog2(DEPTH+1)  number of stores matched so far
//  load_ovf    out  1       sticky: exp_wr seen while queue full (entry dropped)
// BEHAVIOUR
//  Reset: state=IDLE, queue empty, all outputs 0, timeout counter 0.
//  Store event = mem_write==1 at a rising edge and not (IGNORE_EN && data_addr==IGNORE_ADDR).
//  IDLE:
//   - exp_wr with count<DEPTH: appends entry. With count==DEPTH: dropped, load_ovf<=1.
//   - Store events ignored.
//   - start: RUN next cycle. exp_wr in the same cycle as start is still accepted.
//  RUN:
//   - exp_wr ignored.
//   - Store event equal to head (addr and data): pop, match_cnt+1.
//   - Store event unequal to head: FAIL, cause MISMATCH, err_addr/err_data captured; queue frozen.
//   - Queue empty: PASS next cycle. This covers start with an empty queue (PASS 1 cycle after entering RUN)
//     and the pop of the last entry (PASS on the following edge).
//  Timeout:
//   - Counter increments every RUN cycle; when it reaches TIMEOUT-1 without PASS: FAIL, cause TIMEOUT.
//   - A store event on that same edge is evaluated first: match on last entry -> PASS; mismatch -> MISMATCH.
//  PASS:
//   - Terminal.
//   - If STRICT and a store event occurs: FAIL, cause EXTRA, err_* captured.
//  FAIL: terminal, all outputs frozen until reset.
//  Outputs are registered; the response to a store is visible 1 cycle after the sampling edge.
//  Reset asserted in any state wins over all events: next edge returns to reset values, queue flushed.
//  Queue is circular: read/write pointers wrap modulo DEPTH; count is tracked separately, so full and empty are distinct.
// TESTING
//  1 Load (84,7); start; stores (80,1),(84,7) -> pass=1, fail_cause=0, match_cnt=1.
//  2 Load (84,7),(88,9); start; store (88,9) -> fail_cause=1, err_addr=88, err_data=9, match_cnt=0.
//  3 TIMEOUT=20, load (84,7), start, no stores -> done=1 and fail_cause=2 exactly 20 cycles after entering RUN.
//  4 DEPTH=2, three exp_wr -> load_ovf=1; start; stores (a0,d0),(a1,d1) -> pass=1.
//  5 STRICT=1, pass reached, then store (96,3) -> fail_cause=3, err_addr=96; with IGNORE_EN, store (80,x) keeps PASS.
//  6 Reset asserted mid-RUN after 1 match -> next cycle busy=0, match_cnt=0; new load/start behaves as in test 1.

Source files
------------

// File: rtl/mem_write_scoreboard.sv
// Self-checking scoreboard for a core's data-memory write port: compares observed stores
// against a preloaded queue of expected (address, data) pairs and reports pass/fail cause.
module mem_write_scoreboard #(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        DEPTH       = 8,
  parameter int unsigned        TIMEOUT     = 1000,
  parameter bit                 IGNORE_EN   = 1'b1,
  parameter logic [ADDR_W-1:0]  IGNORE_ADDR = ADDR_W'(80),
  parameter bit                 STRICT      = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         exp_wr,
  input  logic [ADDR_W-1:0]            exp_addr,
  input  logic [DATA_W-1:0]            exp_data,
  input  logic                         start,
  input  logic                         mem_write,
  input  logic [ADDR_W-1:0]            data_addr,
  input  logic [DATA_W-1:0]            write_data,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   fail_cause,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [DATA_W-1:0]            err_data,
  output logic [$clog2(DEPTH+1)-1:0]   match_cnt,
  output logic                         load_ovf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] C_MISMATCH = 2'd1;
  localparam logic [1:0] C_TIMEOUT  = 2'd2;
  localparam logic [1:0] C_EXTRA    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [TW-1:0]     tmo_cnt;

  logic       store_ev, head_match, tmo_hit;
  logic       push, pop, capture, set_cause, ovf_set;
  logic [1:0] cause_nxt;

  assign store_ev   = mem_write && !(IGNORE_EN && (data_addr == IGNORE_ADDR));
  assign head_match = (q_addr[rd_ptr] == data_addr) && (q_data[rd_ptr] == write_data);
  assign tmo_hit    = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    pop       = 1'b0;
    capture   = 1'b0;
    set_cause = 1'b0;
    cause_nxt = 2'd0;
    ovf_set   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (exp_wr) begin
          if (count < CW'(DEPTH)) push = 1'b1;
          else                    ovf_set = 1'b1;
        end
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (count == '0) begin
          state_nxt = S_PASS;
        end else if (store_ev && head_match) begin
          pop = 1'b1;
          // A final match on the timeout edge still counts as a pass.
          if (tmo_hit) begin
            if (count == CW'(1)) begin
              state_nxt = S_PASS;
            end else begin
              state_nxt = S_FAIL;
              set_cause = 1'b1;
              cause_nxt = C_TIMEOUT;
            end
          end
        end else if (store_ev) begin
          state_nxt = S_FAIL;
          capture   = 1'b1;
          set_cause = 1'b1;
          cause_nxt = C_MISMATCH;
        end else if (tmo_hit) begin
          state_nxt = S_FAIL;
          set_cause = 1'b1;
          cause_nxt = C_TIMEOUT;
        end
      end
      S_PASS: begin
        if (STRICT && store_ev) begin
          state_nxt = S_FAIL;
          capture   = 1'b1;
          set_cause = 1'b1;
          cause_nxt = C_EXTRA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      match_cnt  <= '0;
      tmo_cnt    <= '0;
      load_ovf   <= 1'b0;
      fail_cause <= 2'd0;
      err_addr   <= '0;
      err_data   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        count     <= count - 1'b1;
        match_cnt <= match_cnt + 1'b1;
      end
      if (state == S_RUN) tmo_cnt <= tmo_cnt + 1'b1;
      if (ovf_set)        load_ovf <= 1'b1;
      if (set_cause)      fail_cause <= cause_nxt;
      if (capture) begin
        err_addr <= data_addr;
        err_data <= write_data;
      end
    end
  end

  // Queue storage carries no reset; occupancy is governed by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= exp_addr;
      q_data[wr_ptr] <= exp_data;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_PASS) || (state == S_FAIL);
  assign pass = (state == S_PASS);

endmodule

// File: tb/tb_mem_write_scoreboard.sv
// Bench for mem_write_scoreboard: directed scenarios plus randomized runs against a
// list-based behavioural model, on two differently parameterised instances.
module tb_mem_write_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, exp_wr, start, mem_write;
  logic [31:0] exp_addr, exp_data, data_addr, write_data;

  logic        busy_a, done_a, pass_a, ovf_a;
  logic [1:0]  cause_a;
  logic [31:0] ea_a, ed_a;
  logic [3:0]  mc_a;
  logic        busy_b, done_b, pass_b, ovf_b;
  logic [1:0]  cause_b;
  logic [31:0] ea_b, ed_b;
  logic [1:0]  mc_b;

  mem_write_scoreboard #(.DEPTH(8), .TIMEOUT(20), .STRICT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .exp_wr(exp_wr), .exp_addr(exp_addr), .exp_data(exp_data),
    .start(start), .mem_write(mem_write), .data_addr(data_addr), .write_data(write_data),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_cause(cause_a),
    .err_addr(ea_a), .err_data(ed_a), .match_cnt(mc_a), .load_ovf(ovf_a));

  mem_write_scoreboard #(.DEPTH(2), .TIMEOUT(0), .STRICT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .exp_wr(exp_wr), .exp_addr(exp_addr), .exp_data(exp_data),
    .start(start), .mem_write(mem_write), .data_addr(data_addr), .write_data(write_data),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_cause(cause_b),
    .err_addr(ea_b), .err_data(ed_b), .match_cnt(mc_b), .load_ovf(ovf_b));

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 idle, 1 run, 2 pass, 3 fail; expected list kept head-first.
  int          ph [2];
  int          n  [2];
  logic [31:0] qa [2][8];
  logic [31:0] qd [2][8];
  int          mc [2];
  bit          ovf[2];
  int          cause[2];
  logic [31:0] ea [2];
  logic [31:0] ed [2];
  int          tc [2];
  int          dep[2]    = '{8, 2};
  int          tmo[2]    = '{20, 0};
  bit          strict[2] = '{1'b0, 1'b1};

  task automatic model_step(input int i);
    bit ev, timed;
    ev = mem_write && (data_addr != 32'd80);
    if (reset) begin
      ph[i] = 0; n[i] = 0; mc[i] = 0; ovf[i] = 1'b0; cause[i] = 0;
      ea[i] = '0; ed[i] = '0; tc[i] = 0;
      return;
    end
    case (ph[i])
      0: begin
        if (exp_wr) begin
          if (n[i] < dep[i]) begin
            qa[i][n[i]] = exp_addr; qd[i][n[i]] = exp_data; n[i]++;
          end else ovf[i] = 1'b1;
        end
        if (start) begin ph[i] = 1; tc[i] = 0; end
      end
      1: begin
        tc[i]++;
        timed = (tmo[i] != 0) && (tc[i] == tmo[i]);
        if (n[i] == 0) ph[i] = 2;
        else if (ev && data_addr == qa[i][0] && write_data == qd[i][0]) begin
          for (int k = 0; k < 7; k++) begin
            qa[i][k] = qa[i][k+1]; qd[i][k] = qd[i][k+1];
          end
          n[i]--; mc[i]++;
          if (timed) begin
            if (n[i] == 0) ph[i] = 2;
            else begin ph[i] = 3; cause[i] = 2; end
          end
        end else if (ev) begin
          ph[i] = 3; cause[i] = 1; ea[i] = data_addr; ed[i] = write_data;
        end else if (timed) begin
          ph[i] = 3; cause[i] = 2;
        end
      end
      2: if (strict[i] && ev) begin
        ph[i] = 3; cause[i] = 3; ea[i] = data_addr; ed[i] = write_data;
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; exp_wr = 1'b0; start = 1'b0; mem_write = 1'b0;
    exp_addr = '0; exp_data = '0; data_addr = '0; write_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input bit st);
    exp_wr = 1'b1; exp_addr = a; exp_data = d; start = st;
    tick();
    exp_wr = 1'b0; start = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; data_addr = a; write_data = d;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; exp_wr = 1'b1; start = 1'b1; mem_write = 1'b1; data_addr = 32'd84;
    tick();
    idle_inputs();
    checks++;
    if ({busy_a, done_a, pass_a, ovf_a} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags_a: got %b expected 0000", {busy_a, done_a, pass_a, ovf_a});
    end
    checks++;
    if ({cause_a, mc_a} !== 6'd0 || ea_a !== 32'd0 || ed_a !== 32'd0) begin
      errors++; $display("FAIL reset_vals_a: got cause=%0d mc=%0d ea=%0d ed=%0d expected all 0", cause_a, mc_a, ea_a, ed_a);
    end
    checks++;
    if ({busy_b, done_b, pass_b, ovf_b, cause_b, mc_b} !== 8'd0) begin
      errors++; $display("FAIL reset_b: got %b expected 0", {busy_b, done_b, pass_b, ovf_b, cause_b, mc_b});
    end
  endtask

  task automatic test_basic();
    do_reset();
    load(32'd84, 32'd7, 1'b0);
    kick();
    store(32'd80, 32'd1);
    store(32'd84, 32'd7);
    checks++;
    if (busy_a !== 1'b1 || mc_a !== 4'd1) begin
      errors++; $display("FAIL basic_popped: got busy=%b mc=%0d expected busy=1 mc=1", busy_a, mc_a);
    end
    tick();
    checks++;
    if (pass_a !== 1'b1 || done_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL basic_pass: got pass=%b done=%b busy=%b expected 1 1 0", pass_a, done_a, busy_a);
    end
    checks++;
    if (cause_a !== 2'd0 || mc_a !== 4'd1) begin
      errors++; $display("FAIL basic_vals: got cause=%0d mc=%0d expected 0 1", cause_a, mc_a);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    load(32'd84, 32'd7, 1'b0);
    load(32'd88, 32'd9, 1'b0);
    kick();
    store(32'd88, 32'd9);
    checks++;
    if (cause_a !== 2'd1 || ea_a !== 32'd88 || ed_a !== 32'd9 || mc_a !== 4'd0) begin
      errors++; $display("FAIL mismatch: got cause=%0d ea=%0d ed=%0d mc=%0d expected 1 88 9 0", cause_a, ea_a, ed_a, mc_a);
    end
    checks++;
    if (done_a !== 1'b1 || pass_a !== 1'b0) begin
      errors++; $display("FAIL mismatch_flags: got done=%b pass=%b expected 1 0", done_a, pass_a);
    end
    store(32'd84, 32'd7);
    store(32'd92, 32'd5);
    checks++;
    if (cause_a !== 2'd1 || ea_a !== 32'd88 || ed_a !== 32'd9 || mc_a !== 4'd0 || done_a !== 1'b1) begin
      errors++; $display("FAIL mismatch_frozen: got cause=%0d ea=%0d ed=%0d mc=%0d expected 1 88 9 0", cause_a, ea_a, ed_a, mc_a);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    load(32'd84, 32'd7, 1'b1);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL timeout_enter: got busy=%b expected 1", busy_a);
    end
    for (int c = 0; c < 19; c++) tick();
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL timeout_early: got done=%b busy=%b expected 0 1", done_a, busy_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b1 || cause_a !== 2'd2 || ea_a !== 32'd0 || ed_a !== 32'd0) begin
      errors++; $display("FAIL timeout_hit: got done=%b cause=%0d ea=%0d ed=%0d expected 1 2 0 0", done_a, cause_a, ea_a, ed_a);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] a[3], d[3];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a[k] = 32'($urandom_range(100, 200) * 4);
      d[k] = $urandom;
    end
    load(a[0], d[0], 1'b0);
    load(a[1], d[1], 1'b0);
    checks++;
    if (ovf_b !== 1'b0) begin
      errors++; $display("FAIL ovf_full_ok: got %b expected 0", ovf_b);
    end
    load(a[2], d[2], 1'b0);
    checks++;
    if (ovf_b !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %b expected 1", ovf_b);
    end
    kick();
    store(a[0], d[0]);
    store(a[1], d[1]);
    tick();
    checks++;
    if (pass_b !== 1'b1 || mc_b !== 2'd2 || cause_b !== 2'd0 || ovf_b !== 1'b1) begin
      errors++; $display("FAIL ovf_pass: got pass=%b mc=%0d cause=%0d ovf=%b expected 1 2 0 1", pass_b, mc_b, cause_b, ovf_b);
    end
  endtask

  task automatic test_strict();
    do_reset();
    load(32'd84, 32'd7, 1'b0);
    kick();
    store(32'd84, 32'd7);
    tick();
    checks++;
    if (pass_b !== 1'b1) begin
      errors++; $display("FAIL strict_pass: got %b expected 1", pass_b);
    end
    store(32'd80, $urandom);
    checks++;
    if (pass_b !== 1'b1 || done_b !== 1'b1) begin
      errors++; $display("FAIL strict_ignored: got pass=%b done=%b expected 1 1", pass_b, done_b);
    end
    store(32'd96, 32'd3);
    checks++;
    if (cause_b !== 2'd3 || ea_b !== 32'd96 || ed_b !== 32'd3 || pass_b !== 1'b0 || done_b !== 1'b1) begin
      errors++; $display("FAIL strict_extra: got cause=%0d ea=%0d ed=%0d pass=%b done=%b expected 3 96 3 0 1", cause_b, ea_b, ed_b, pass_b, done_b);
    end
    checks++;
    if (pass_a !== 1'b1 || cause_a !== 2'd0) begin
      errors++; $display("FAIL nonstrict_extra: got pass=%b cause=%0d expected 1 0", pass_a, cause_a);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load(32'd84, 32'd7, 1'b0);
    load(32'd88, 32'd9, 1'b0);
    kick();
    store(32'd84, 32'd7);
    checks++;
    if (mc_a !== 4'd1 || busy_a !== 1'b1) begin
      errors++; $display("FAIL midrun_before: got mc=%0d busy=%b expected 1 1", mc_a, busy_a);
    end
    reset = 1'b1; mem_write = 1'b1; data_addr = 32'd88; write_data = 32'd9;
    tick();
    idle_inputs();
    checks++;
    if (busy_a !== 1'b0 || mc_a !== 4'd0 || done_a !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: got busy=%b mc=%0d done=%b expected 0 0 0", busy_a, mc_a, done_a);
    end
    load(32'd84, 32'd7, 1'b0);
    kick();
    store(32'd80, 32'd1);
    store(32'd84, 32'd7);
    tick();
    checks++;
    if (pass_a !== 1'b1 || cause_a !== 2'd0 || mc_a !== 4'd1) begin
      errors++; $display("FAIL midrun_rerun: got pass=%b cause=%0d mc=%0d expected 1 0 1", pass_a, cause_a, mc_a);
    end
  endtask

  task automatic test_random();
    int nl, r;
    for (int it = 0; it < 40; it++) begin
      do_reset();
      nl = $urandom_range(0, 9);
      for (int j = 0; j < nl; j++)
        load(32'(84 + 4 * $urandom_range(0, 4)), 32'($urandom_range(0, 3)), (j == nl - 1) && ($urandom_range(0, 1) == 1));
      if (ph[0] == 0) kick();
      for (int c = 0; c < 30; c++) begin
        r = $urandom_range(0, 9);
        mem_write = 1'b1;
        if (r < 5 && n[0] > 0)      begin data_addr = qa[0][0]; write_data = qd[0][0]; end
        else if (r < 6 && n[1] > 0) begin data_addr = qa[1][0]; write_data = qd[1][0]; end
        else if (r < 7)             begin data_addr = 32'd80; write_data = $urandom; end
        else if (r < 8)             mem_write = 1'b0;
        else begin
          data_addr = 32'(84 + 4 * $urandom_range(0, 4)); write_data = 32'($urandom_range(0, 3));
        end
        exp_wr = ($urandom_range(0, 4) == 0);
        exp_addr = 32'd84; exp_data = 32'd0;
        start = ($urandom_range(0, 4) == 0);
        reset = ($urandom_range(0, 49) == 0);
        tick();
        checks++;
        if ({busy_a, done_a, pass_a, ovf_a, cause_a} !== {ph[0] == 1, ph[0] >= 2, ph[0] == 2, ovf[0], 2'(cause[0])}
            || mc_a !== 4'(mc[0]) || ea_a !== ea[0] || ed_a !== ed[0]) begin
          errors++;
          $display("FAIL rand_a it=%0d c=%0d: got b/d/p/o=%b cause=%0d mc=%0d ea=%0d ed=%0d expected phase=%0d ovf=%b cause=%0d mc=%0d ea=%0d ed=%0d",
                   it, c, {busy_a, done_a, pass_a, ovf_a}, cause_a, mc_a, ea_a, ed_a, ph[0], ovf[0], cause[0], mc[0], ea[0], ed[0]);
        end
        checks++;
        if ({busy_b, done_b, pass_b, ovf_b, cause_b} !== {ph[1] == 1, ph[1] >= 2, ph[1] == 2, ovf[1], 2'(cause[1])}
            || mc_b !== 2'(mc[1]) || ea_b !== ea[1] || ed_b !== ed[1]) begin
          errors++;
          $display("FAIL rand_b it=%0d c=%0d: got b/d/p/o=%b cause=%0d mc=%0d ea=%0d ed=%0d expected phase=%0d ovf=%b cause=%0d mc=%0d ea=%0d ed=%0d",
                   it, c, {busy_b, done_b, pass_b, ovf_b}, cause_b, mc_b, ea_b, ed_b, ph[1], ovf[1], cause[1], mc[1], ea[1], ed[1]);
        end
      end
      idle_inputs();
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_basic();
    test_mismatch();
    test_timeout();
    test_overflow();
    test_strict();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
